// File: rtl/interval_timer.sv
// interval_timer: programmable countdown timer with prescaler.
// A start request loads the tick count. The timer counts down one step per
// PRESCALE clocks. It raises int_out when the count expires, in one-shot
// or periodic (auto-reload) mode.
// Optional build macro INTERVAL_TIMER_STICKY_INT_EN: adds int_ack_in.
// With the macro defined, int_out holds after expiry until it is acknowledged.
module interval_timer #(
    parameter int COUNT_WIDTH = 24,
    parameter int PRESCALE    = 12
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    // Request interface: start_in and stop_in are single-cycle requests
    // sampled on every rising edge and always accepted (no back-pressure).
    // Priority is stop > start > expiry.
    input  logic                   start_in,
    input  logic                   stop_in,
    input  logic [COUNT_WIDTH-1:0] load_value_in,
    input  logic                   periodic_in,
`ifdef INTERVAL_TIMER_STICKY_INT_EN
    input  logic                   int_ack_in,
`endif
    output logic                   int_out,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] count_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]          PS_LAST   = PW'(PRESCALE - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [PW-1:0]          prescaler;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] load_q;
    logic                   periodic_q;
    logic                   int_q;

    logic                   tick;
    logic                   expire;
    logic [COUNT_WIDTH-1:0] start_load;

    // Tick/expiry decode. A zero load is promoted to one so that a start
    // always produces an expiry. Stop and restart both mask the expiry.
    always_comb begin
        start_load = (load_value_in == '0) ? COUNT_ONE : load_value_in;
        tick       = (state == RUN) && (prescaler == PS_LAST);
        expire     = tick && (count == COUNT_ONE) && !stop_in && !start_in;
    end

    // Control FSM, prescaler, count and registered interrupt.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state      <= IDLE;
            prescaler  <= '0;
            count      <= '0;
            load_q     <= '0;
            periodic_q <= 1'b0;
            int_q      <= 1'b0;
        end else begin
`ifdef INTERVAL_TIMER_STICKY_INT_EN
            // A new expiry wins over an acknowledge on the same edge.
            int_q <= expire | (int_q & ~int_ack_in);
`else
            int_q <= expire;
`endif
            case (state)
                IDLE: begin
                    if (start_in && !stop_in) begin
                        load_q     <= start_load;
                        periodic_q <= periodic_in;
                        count      <= start_load;
                        prescaler  <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (stop_in) begin
                        state     <= IDLE;
                        count     <= '0;
                        prescaler <= '0;
                    end else if (start_in) begin
                        load_q     <= start_load;
                        periodic_q <= periodic_in;
                        count      <= start_load;
                        prescaler  <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (count == COUNT_ONE) begin
                            if (periodic_q) begin
                                count <= load_q;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                            end
                        end else if (count != '0) begin
                            count <= count - COUNT_ONE;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign int_out   = int_q;
    assign busy_out  = (state == RUN);
    assign count_out = count;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer (COUNT_WIDTH=8, PRESCALE=4 plus a PRESCALE=1 copy).
// Edge numbering: edge_n is the number of rising edges seen so far. Inputs
// are driven and outputs sampled on the falling edge. "After edge k" means
// the sample taken while edge_n == k.
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         edge_n = 0;

    // Main DUT (PRESCALE=4)
    logic       start = 1'b0, stop = 1'b0, periodic = 1'b0;
    logic [7:0] load = 8'd0;
    logic       int_o, busy_o;
    logic [7:0] count_o;

    // PRESCALE=1 DUT
    logic       start1 = 1'b0;
    logic [7:0] load1 = 8'd0;
    logic       int1_o, busy1_o;
    logic [7:0] count1_o;

`ifdef INTERVAL_TIMER_STICKY_INT_EN
    logic       ack = 1'b0;
`endif

    int         checks = 0;
    int         failures = 0;
    int         e0;

    logic [31:0] exp_q[$];
    logic [31:0] exp1_q[$];

    interval_timer #(.COUNT_WIDTH(8), .PRESCALE(4)) u_dut (
        .clock_in      (clk),
        .reset_in      (rst),
        .start_in      (start),
        .stop_in       (stop),
        .load_value_in (load),
        .periodic_in   (periodic),
`ifdef INTERVAL_TIMER_STICKY_INT_EN
        .int_ack_in    (ack),
`endif
        .int_out       (int_o),
        .busy_out      (busy_o),
        .count_out     (count_o)
    );

    interval_timer #(.COUNT_WIDTH(8), .PRESCALE(1)) u_p1 (
        .clock_in      (clk),
        .reset_in      (rst),
        .start_in      (start1),
        .stop_in       (1'b0),
        .load_value_in (load1),
        .periodic_in   (1'b0),
`ifdef INTERVAL_TIMER_STICKY_INT_EN
        .int_ack_in    (1'b0),
`endif
        .int_out       (int1_o),
        .busy_out      (busy1_o),
        .count_out     (count1_o)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Check helper
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Driver tasks
    task automatic wait_until(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] ld, input logic per);
        start = 1'b1; load = ld; periodic = per;
        @(negedge clk);
        start = 1'b0; periodic = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic pulse_both(input logic [7:0] ld);
        start = 1'b1; stop = 1'b1; load = ld;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

`ifndef INTERVAL_TIMER_STICKY_INT_EN
    // Scoreboard monitors: each interrupt pulse must match the next expected edge.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0] < 32'(edge_n)) begin
                checks++; failures++;
                $display("FAIL int_missed actual=none expected_edge=%0d", exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (int_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL int_unexpected actual_edge=%0d expected=none", edge_n);
                end else if (exp_q.pop_front() != 32'(edge_n)) begin
                    failures++;
                    $display("FAIL int_timing actual_edge=%0d expected other edge", edge_n);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            while (exp1_q.size() > 0 && exp1_q[0] < 32'(edge_n)) begin
                checks++; failures++;
                $display("FAIL p1_int_missed actual=none expected_edge=%0d", exp1_q[0]);
                void'(exp1_q.pop_front());
            end
            if (int1_o) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    failures++;
                    $display("FAIL p1_int_unexpected actual_edge=%0d expected=none", edge_n);
                end else if (exp1_q.pop_front() != 32'(edge_n)) begin
                    failures++;
                    $display("FAIL p1_int_timing actual_edge=%0d expected other edge", edge_n);
                end
            end
        end
    end
`endif

    // Stimulus
    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_int", int_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_count", count_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifndef INTERVAL_TIMER_STICKY_INT_EN
        // One-shot, load 5
        e0 = edge_n + 1;
        exp_q.push_back(32'(e0 + 20));
        pulse_start(8'd5, 1'b0);
        for (int k = 0; k <= 21; k++) begin
            wait_until(e0 + k);
            chk("oneshot_count", count_o, (k < 20) ? 5 - k / 4 : 0);
            chk("oneshot_busy", busy_o, (k < 20) ? 1 : 0);
        end

        // Periodic, load 3, stopped at edge 30
        wait_until(edge_n + 3);
        e0 = edge_n + 1;
        exp_q.push_back(32'(e0 + 12));
        exp_q.push_back(32'(e0 + 24));
        pulse_start(8'd3, 1'b1);
        wait_until(e0 + 12);
        chk("periodic_reload", count_o, 3);
        chk("periodic_busy", busy_o, 1);
        wait_until(e0 + 29);
        pulse_stop();
        chk("stop_busy", busy_o, 0);
        chk("stop_count", count_o, 0);
        wait_until(e0 + 40);

        // Restart with load 2 at edge 10
        e0 = edge_n + 1;
        pulse_start(8'd5, 1'b0);
        wait_until(e0 + 9);
        exp_q.push_back(32'(e0 + 18));
        pulse_start(8'd2, 1'b0);
        chk("restart_count", count_o, 2);
        wait_until(e0 + 26);

        // Start coincident with the expiry tick
        e0 = edge_n + 1;
        pulse_start(8'd2, 1'b0);
        wait_until(e0 + 7);
        exp_q.push_back(32'(e0 + 20));
        pulse_start(8'd3, 1'b0);
        chk("coinc_count", count_o, 3);
        chk("coinc_busy", busy_o, 1);
        wait_until(e0 + 24);

        // Start+stop in IDLE and in RUN
        pulse_both(8'd4);
        chk("both_idle_busy", busy_o, 0);
        e0 = edge_n + 1;
        pulse_start(8'd5, 1'b0);
        wait_until(e0 + 2);
        pulse_both(8'd7);
        chk("both_run_busy", busy_o, 0);
        chk("both_run_count", count_o, 0);
        wait_until(e0 + 30);

        // Load 0 behaves as load 1
        e0 = edge_n + 1;
        exp_q.push_back(32'(e0 + 4));
        pulse_start(8'd0, 1'b0);
        chk("load0_count", count_o, 1);
        wait_until(e0 + 6);

        // PRESCALE=1, load 1
        e0 = edge_n + 1;
        exp1_q.push_back(32'(e0 + 1));
        start1 = 1'b1; load1 = 8'd1;
        @(negedge clk);
        start1 = 1'b0;
        chk("p1_count", count1_o, 1);
        chk("p1_busy", busy1_o, 1);
        wait_until(e0 + 3);
        chk("p1_idle", busy1_o, 0);

        // Load 255, no wrap
        e0 = edge_n + 1;
        exp_q.push_back(32'(e0 + 1020));
        pulse_start(8'd255, 1'b0);
        chk("l255_start", count_o, 255);
        wait_until(e0 + 1019);
        chk("l255_last", count_o, 1);
        wait_until(e0 + 1020);
        chk("l255_end_count", count_o, 0);
        chk("l255_end_busy", busy_o, 0);
        wait_until(e0 + 1030);
        chk("l255_nowrap", count_o, 0);

        // Asynchronous reset mid-run
        e0 = edge_n + 1;
        pulse_start(8'd5, 1'b0);
        wait_until(e0 + 7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_int", int_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_count", count_o, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_until(edge_n + 30);
        chk("postrst_busy", busy_o, 0);

        chk("sb_empty", exp_q.size(), 0);
        chk("sb1_empty", exp1_q.size(), 0);
`else
        // Sticky one-shot, load 2: held from edge 8 until the ack at edge 15
        e0 = edge_n + 1;
        pulse_start(8'd2, 1'b0);
        wait_until(e0 + 7);
        chk("sticky_pre", int_o, 0);
        for (int k = 8; k <= 14; k++) begin
            wait_until(e0 + k);
            chk("sticky_hold", int_o, 1);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("sticky_acked", int_o, 0);
        chk("sticky_busy", busy_o, 0);

        // Ack coincident with a periodic expiry keeps int set
        e0 = edge_n + 1;
        pulse_start(8'd2, 1'b1);
        wait_until(e0 + 8);
        chk("sticky_per_set", int_o, 1);
        wait_until(e0 + 15);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("sticky_ack_coinc", int_o, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("sticky_ack_clear", int_o, 0);
        pulse_stop();
        chk("sticky_stop_busy", busy_o, 0);
        chk("sticky_stop_int", int_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
